// File: rtl/conv_window3x3_if.sv
// Handshake bundle for conv_window3x3: pixel stream in, 3x3 window out.
// The master drives pixels and window ready; the slave is the window generator.
interface conv_window3x3_if;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic              win_valid;
  logic              win_ready;
  logic signed [7:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic              frame_done;

  modport master (
    output in_valid, in_data, win_ready,
    input  in_ready, win_valid, frame_done,
    input  win0, win1, win2, win3, win4, win5, win6, win7, win8
  );

  modport slave (
    input  in_valid, in_data, win_ready,
    output in_ready, win_valid, frame_done,
    output win0, win1, win2, win3, win4, win5, win6, win7, win8
  );
endinterface

// File: rtl/conv_window3x3.sv
// Streaming 3x3 sliding-window generator over two row line buffers.
// Define CONV_WIN_STRIDE2_EN to emit only windows at even (row-2, col-2), i.e. stride 2.
module conv_window3x3 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic          clk,
  input  logic          rst,
  conv_window3x3_if.slave s
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [2:0][2:0][7:0] w_q, w_d;
  logic                 win_valid_q, win_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic signed [7:0]    lb_a [IMG_W];
  logic signed [7:0]    lb_b [IMG_W];

  logic acc, last_col, last_row, emit_pos;

  assign s.in_ready = !win_valid_q || s.win_ready;
  assign acc        = s.in_valid && s.in_ready;
  assign last_col   = (col_q == CW'(IMG_W - 1));
  assign last_row   = (row_q == RW'(IMG_H - 1));

`ifdef CONV_WIN_STRIDE2_EN
  // (row-2) even is the same as row even.
  assign emit_pos = (row_q >= RW'(2)) && (col_q >= CW'(2)) && !row_q[0] && !col_q[0];
`else
  assign emit_pos = (row_q >= RW'(2)) && (col_q >= CW'(2));
`endif

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    w_d          = w_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;
    if (win_valid_q && s.win_ready) win_valid_d = 1'b0;
    if (acc) begin
      for (int r = 0; r < 3; r++) begin
        w_d[r][0] = w_q[r][1];
        w_d[r][1] = w_q[r][2];
      end
      w_d[0][2] = lb_b[col_q];
      w_d[1][2] = lb_a[col_q];
      w_d[2][2] = s.in_data;
      if (emit_pos) win_valid_d = 1'b1;
      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      w_q          <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      w_q          <= w_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers carry no reset; the counters decide what is valid.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb_b[col_q] <= lb_a[col_q];
      lb_a[col_q] <= s.in_data;
    end
  end

  assign s.win_valid  = win_valid_q;
  assign s.frame_done = frame_done_q;
  assign s.win0 = w_q[0][0];
  assign s.win1 = w_q[0][1];
  assign s.win2 = w_q[0][2];
  assign s.win3 = w_q[1][0];
  assign s.win4 = w_q[1][1];
  assign s.win5 = w_q[1][2];
  assign s.win6 = w_q[2][0];
  assign s.win7 = w_q[2][1];
  assign s.win8 = w_q[2][2];
endmodule

// File: tb/tb_conv_window3x3.sv
// Directed bench for conv_window3x3: 4x4, 3x3 and 5x5 instances behind one shared driver.
module tb_conv_window3x3;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       win_ready = 1'b1;
  int         sel = 0;
  int         n_chk = 0;
  int         n_err = 0;
  int         fd_cnt = 0;
  logic [71:0] wq[$];

  always #5 clk = ~clk;

  conv_window3x3_if i4 ();
  conv_window3x3_if i3 ();
  conv_window3x3_if i5 ();

  conv_window3x3 #(.IMG_W(4), .IMG_H(4)) u4 (.clk(clk), .rst(rst), .s(i4.slave));
  conv_window3x3 #(.IMG_W(3), .IMG_H(3)) u3 (.clk(clk), .rst(rst), .s(i3.slave));
  conv_window3x3 #(.IMG_W(5), .IMG_H(5)) u5 (.clk(clk), .rst(rst), .s(i5.slave));

  assign i4.in_valid = in_valid && (sel == 0);
  assign i3.in_valid = in_valid && (sel == 1);
  assign i5.in_valid = in_valid && (sel == 2);
  assign i4.in_data = in_data;
  assign i3.in_data = in_data;
  assign i5.in_data = in_data;
  assign i4.win_ready = win_ready;
  assign i3.win_ready = win_ready;
  assign i5.win_ready = win_ready;

  wire [71:0] pk4 = {i4.win0, i4.win1, i4.win2, i4.win3, i4.win4, i4.win5, i4.win6, i4.win7, i4.win8};
  wire [71:0] pk3 = {i3.win0, i3.win1, i3.win2, i3.win3, i3.win4, i3.win5, i3.win6, i3.win7, i3.win8};
  wire [71:0] pk5 = {i5.win0, i5.win1, i5.win2, i5.win3, i5.win4, i5.win5, i5.win6, i5.win7, i5.win8};
  wire [71:0] win_pk    = (sel == 0) ? pk4 : (sel == 1) ? pk3 : pk5;
  wire        win_valid = (sel == 0) ? i4.win_valid : (sel == 1) ? i3.win_valid : i5.win_valid;
  wire        in_ready  = (sel == 0) ? i4.in_ready : (sel == 1) ? i3.in_ready : i5.in_ready;
  wire        fdone     = (sel == 0) ? i4.frame_done : (sel == 1) ? i3.frame_done : i5.frame_done;

  always @(negedge clk) begin
    if (!rst && win_valid && win_ready) wq.push_back(win_pk);
    if (!rst && fdone) fd_cnt++;
  end

  task automatic chk(string tag, logic [71:0] got, logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Window whose top-left pixel value is tl in a raster of pixel values 0,1,2,... of width w.
  function automatic logic [71:0] mk(int tl, int w);
    logic [71:0] v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v = {v[63:0], 8'(tl + r * w + c)};
    return v;
  endfunction

  task automatic send(logic [7:0] p);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = p;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 72'(ok), 72'd1);
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic clr();
    wq.delete();
    fd_cnt = 0;
  endtask

  logic [7:0] sv [9] = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h40, 8'hC0, 8'h05};

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_in_ready", 72'(in_ready), 72'd1);
    chk("rst_win_valid", 72'(win_valid), 72'd0);
    chk("rst_win", win_pk, 72'd0);
    chk("rst_frame_done", 72'(fdone), 72'd0);

    // Signed passthrough on a 3x3 frame: single window, either stride.
    sel = 1; clr();
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) send(sv[i]);
    drain();
    chk("sgn_count", 72'(wq.size()), 72'd1);
    chk("sgn_win", (wq.size() > 0) ? wq[0] : 72'hX, 72'h807FFF0001FE40C005);

`ifdef CONV_WIN_STRIDE2_EN
    sel = 2; clr();
    for (int i = 0; i < 25; i++) send(8'(i));
    @(negedge clk);
    chk("s2_frame_done", 72'(fdone), 72'd1);
    drain();
    chk("s2_count", 72'(wq.size()), 72'd4);
    chk("s2_win0", wq[0], mk(0, 5));
    chk("s2_win1", wq[1], mk(2, 5));
    chk("s2_win2", wq[2], mk(10, 5));
    chk("s2_win3", wq[3], mk(12, 5));
    chk("s2_fd_cnt", 72'(fd_cnt), 72'd1);
`else
    // Free-flowing 4x4 frame.
    sel = 0; clr();
    for (int i = 0; i < 16; i++) send(8'(i));
    @(negedge clk);
    chk("t1_frame_done", 72'(fdone), 72'd1);
    @(negedge clk);
    chk("t1_frame_done_low", 72'(fdone), 72'd0);
    drain();
    chk("t1_count", 72'(wq.size()), 72'd4);
    chk("t1_win0", wq[0], mk(0, 4));
    chk("t1_win1", wq[1], mk(1, 4));
    chk("t1_win2", wq[2], mk(4, 4));
    chk("t1_win3", wq[3], mk(5, 4));
    chk("t1_fd_cnt", 72'(fd_cnt), 72'd1);

    // Same stream with a 5-cycle downstream stall after the first window.
    clr();
    fork
      begin
        for (int i = 0; i < 16; i++) send(8'(i));
      end
      begin
        int k = 0;
        while (wq.size() < 1 && k < 200) begin
          @(posedge clk);
          k++;
        end
        if (k >= 200) chk("t2_wait_timeout", 72'(wq.size()), 72'd1);
        #1 win_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("t2_stall_in_ready", 72'(in_ready), 72'd0);
          chk("t2_stall_valid", 72'(win_valid), 72'd1);
          chk("t2_stall_hold", win_pk, mk(1, 4));
        end
        @(posedge clk);
        #1 win_ready = 1'b1;
      end
    join
    drain();
    chk("t2_count", 72'(wq.size()), 72'd4);
    chk("t2_win0", wq[0], mk(0, 4));
    chk("t2_win1", wq[1], mk(1, 4));
    chk("t2_win2", wq[2], mk(4, 4));
    chk("t2_win3", wq[3], mk(5, 4));

    // Reset after 7 pixels, then a fresh frame 100..115.
    for (int i = 0; i < 7; i++) send(8'(i));
    do_reset();
    @(negedge clk);
    chk("t4_rst_valid", 72'(win_valid), 72'd0);
    chk("t4_rst_win", win_pk, 72'd0);
    clr();
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) send(8'(100 + i));
    drain();
    chk("t4_count", 72'(wq.size()), 72'd4);
    chk("t4_win0", wq[0], mk(100, 4));
    chk("t4_win3", wq[3], mk(105, 4));
    chk("t4_fd_cnt", 72'(fd_cnt), 72'd1);

    // Two back-to-back frames.
    clr();
    for (int i = 0; i < 32; i++) send(8'(i));
    drain();
    chk("t5_count", 72'(wq.size()), 72'd8);
    chk("t5_f1_win0", wq[0], mk(0, 4));
    chk("t5_f2_win0", wq[4], mk(16, 4));
    chk("t5_f2_win3", wq[7], mk(21, 4));
    chk("t5_fd_cnt", 72'(fd_cnt), 72'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
